lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL define parameter XLEN, default 32, the data/address width.
REQ-002 SHALL define parameter LD_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5 as the mem_ld_ops encoding; ST_NONE=0, SB=1, SH=2, SW=3 as the mem_st_ops encoding.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  synchronous reset, active-high (1 = reset).
REQ-006 exe_valid_i  in  1  instruction present from execute.
REQ-007 alu_result_i  in  XLEN  effective address.
REQ-008 rs2_data_i  in  XLEN  store data.
REQ-009 mem_ld_ops_i  in  3  load type.
REQ-010 mem_st_ops_i  in  2  store type.
REQ-011 flush_i  in  1  kill the current instruction.
REQ-012 dbus_req_o  out  1  bus request; dbus_we_o  out  1  write enable; dbus_addr_o  out  XLEN  byte address; dbus_wdata_o  out  XLEN  lane-aligned write data; dbus_sel_o  out  4  byte-lane enables.
REQ-013 dbus_ack_i  in  1  transaction complete; dbus_rdata_i  in  XLEN  read word, valid with ack.
REQ-014 stall_o  out  1  upstream holds its inputs.
REQ-015 lsu_done_o  out  1  one-cycle completion pulse; lsu_rdata_o  out  XLEN  formatted load data.
REQ-016 ld_misalign_o / st_misalign_o  out  1 each  misaligned-access exception; exc_addr_o  out  XLEN  faulting address.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP.
REQ-018 A memory op is exe_valid_i & ~flush_i & (ld_ops!=0 | st_ops!=0); if both are nonzero, the load takes priority.
REQ-019 Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; the check is combinational in IDLE only.
REQ-020 IDLE + misaligned op: ld/st_misalign_o=1 and exc_addr_o=alu_result_i in the same cycle, no bus request, stall_o=0, state stays IDLE.
REQ-021 IDLE + aligned op: stall_o=1 combinationally; register addr, we, sel, wdata, ld type and addr[1:0]; next state BUS.
REQ-022 BUS: dbus_req_o=1 with all dbus_* outputs held stable until the ack cycle; stall_o=1.
REQ-023 BUS + dbus_ack_i: register lsu_rdata_o from dbus_rdata_i (load) or 0 (store); next state RESP.
REQ-024 RESP: lsu_done_o=1 for exactly one cycle, stall_o=0, inputs ignored; next state IDLE unconditionally.
REQ-025 Minimum occupancy: accept T, req T+1, ack T+1, done T+2; an op accepted at T occupies the block for 3 cycles, stall_o asserted during T and T+1.
REQ-026 Store lanes: SB sel=4'b0001<<addr[1:0], wdata=byte replicated x4; SH sel=4'b0011<<addr[1:0], wdata=half replicated x2; SW sel=4'b1111, wdata=rs2.
REQ-027 Loads shift dbus_rdata_i right by 8*addr[1:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-028 dbus_addr_o carries the full byte address; loads drive sel as for stores of the same width.
REQ-029 flush_i in IDLE suppresses acceptance and exceptions.
REQ-030 flush_i in BUS SHALL NOT drop dbus_req_o; a latched kill flag discards the ack, skips RESP (no lsu_done_o), and returns to IDLE.
REQ-031 Non-memory instructions in IDLE pass with stall_o=0 and no outputs.

Reset
REQ-032 On rst_n=1 at a clock edge: state=IDLE and kill flag=0.
REQ-033 On rst_n=1 at a clock edge, all registered outputs and dbus_* are 0, and lsu_rdata_o=0.
REQ-034 Reset SHALL abort a BUS-state transaction immediately; a later stray ack is ignored in IDLE.

Verification
REQ-035 LB addr=0x1003, ack in the first BUS cycle with rdata=0x80FF_FF12 -> sel=1000, lsu_rdata_o=0xFFFF_FF80, done at T+2.
REQ-036 SH addr=0x2002, rs2=0x1234_ABCD -> we=1, sel=1100, wdata=0xABCD_ABCD; ack delayed 3 cycles -> req held 4 cycles, stall_o=1 throughout.
REQ-037 LW addr=0x1001 -> ld_misalign_o=1, exc_addr_o=0x1001, dbus_req_o never asserts, stall_o=0.
REQ-038 LHU addr=0x0002, rdata=0xBEEF_0000 -> lsu_rdata_o=0x0000_BEEF.
REQ-039 flush_i in the second BUS cycle, ack on the fourth -> req held to ack, no lsu_done_o, IDLE next.
REQ-040 rst_n=1 during BUS -> next cycle dbus_req_o=0, state IDLE; a following ack produces no done.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store unit stage: turns execute-stage memory ops into single data-bus
// transactions, formats load data and reports misaligned accesses.
module lsu_stage #(
    parameter int         XLEN    = 32,
    parameter logic [2:0] LD_NONE = 3'd0,
    parameter logic [2:0] LB      = 3'd1,
    parameter logic [2:0] LH      = 3'd2,
    parameter logic [2:0] LW      = 3'd3,
    parameter logic [2:0] LBU     = 3'd4,
    parameter logic [2:0] LHU     = 3'd5,
    parameter logic [1:0] ST_NONE = 2'd0,
    parameter logic [1:0] SB      = 2'd1,
    parameter logic [1:0] SH      = 2'd2,
    parameter logic [1:0] SW      = 2'd3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exe_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [2:0]      mem_ld_ops_i,
    input  logic [1:0]      mem_st_ops_i,
    input  logic            flush_i,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [3:0]      dbus_sel_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic            stall_o,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            ld_misalign_o,
    output logic            st_misalign_o,
    output logic [XLEN-1:0] exc_addr_o
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state;
    logic            kill;
    logic [2:0]      ld_type;
    logic [1:0]      ld_off;

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic            in_idle;
    logic [1:0]      off;
    logic            acc_byte;
    logic            acc_half;
    logic            acc_word;
    logic            misaligned;
    logic            take_exc;
    logic            accept;
    logic [3:0]      acc_sel;
    logic [XLEN-1:0] acc_wdata;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Decode the incoming op; a load wins over a store when both are present.
    always_comb begin
        is_load    = (mem_ld_ops_i != LD_NONE);
        is_store   = (mem_st_ops_i != ST_NONE);
        mem_op     = exe_valid_i & ~flush_i & (is_load | is_store);
        in_idle    = (state == IDLE);
        off        = alu_result_i[1:0];
        acc_byte   = is_load ? ((mem_ld_ops_i == LB) | (mem_ld_ops_i == LBU)) : (mem_st_ops_i == SB);
        acc_half   = is_load ? ((mem_ld_ops_i == LH) | (mem_ld_ops_i == LHU)) : (mem_st_ops_i == SH);
        acc_word   = is_load ? (mem_ld_ops_i == LW) : (mem_st_ops_i == SW);
        misaligned = (acc_half & off[0]) | (acc_word & (off != 2'b00));
        take_exc   = in_idle & mem_op & misaligned;
        accept     = in_idle & mem_op & ~misaligned;
        if (acc_byte) begin
            acc_sel   = 4'b0001 << off;
            acc_wdata = {(XLEN/8){rs2_data_i[7:0]}};
        end else if (acc_half) begin
            acc_sel   = 4'b0011 << off;
            acc_wdata = {(XLEN/16){rs2_data_i[15:0]}};
        end else begin
            acc_sel   = 4'b1111;
            acc_wdata = rs2_data_i;
        end
    end

    assign ld_misalign_o = take_exc & is_load;
    assign st_misalign_o = take_exc & ~is_load;
    assign exc_addr_o    = take_exc ? alu_result_i : '0;
    assign stall_o       = accept | (state == BUS);

    // Align the returned word to the accessed byte lane and extend it.
    always_comb begin
        shifted = dbus_rdata_i >> {ld_off, 3'b000};
        case (ld_type)
            LB:      load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LBU:     load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LHU:     load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Transaction FSM: accept in IDLE, hold the bus request until ack, pulse done.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            kill         <= 1'b0;
            ld_type      <= LD_NONE;
            ld_off       <= 2'b00;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_wdata_o <= '0;
            dbus_sel_o   <= 4'b0000;
            lsu_done_o   <= 1'b0;
            lsu_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lsu_done_o <= 1'b0;
                    if (accept) begin
                        state        <= BUS;
                        kill         <= 1'b0;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= ~is_load;
                        dbus_addr_o  <= alu_result_i;
                        dbus_sel_o   <= acc_sel;
                        dbus_wdata_o <= is_load ? '0 : acc_wdata;
                        ld_type      <= is_load ? mem_ld_ops_i : LD_NONE;
                        ld_off       <= off;
                    end
                end
                BUS: begin
                    if (dbus_ack_i) begin
                        dbus_req_o   <= 1'b0;
                        dbus_we_o    <= 1'b0;
                        dbus_addr_o  <= '0;
                        dbus_wdata_o <= '0;
                        dbus_sel_o   <= 4'b0000;
                        kill         <= 1'b0;
                        if (kill | flush_i) begin
                            state <= IDLE;
                        end else begin
                            state       <= RESP;
                            lsu_done_o  <= 1'b1;
                            lsu_rdata_o <= dbus_we_o ? '0 : load_data;
                        end
                    end else if (flush_i) begin
                        kill <= 1'b1;
                    end
                end
                RESP: begin
                    lsu_done_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: expected bus requests and load results are
// queued when an op is driven and compared when the DUT issues/completes it.
module tb_lsu_stage;

    localparam logic [2:0] LD_NONE = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;
    localparam logic [1:0] ST_NONE = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_data_i;
    logic [2:0]  mem_ld_ops_i;
    logic [1:0]  mem_st_ops_i;
    logic        flush_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_sel_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        stall_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        ld_misalign_o;
    logic        st_misalign_o;
    logic [31:0] exc_addr_o;

    lsu_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .exe_valid_i(exe_valid_i), .alu_result_i(alu_result_i),
        .rs2_data_i(rs2_data_i), .mem_ld_ops_i(mem_ld_ops_i), .mem_st_ops_i(mem_st_ops_i),
        .flush_i(flush_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o),
        .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o), .ld_misalign_o(ld_misalign_o),
        .st_misalign_o(st_misalign_o), .exc_addr_o(exc_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] res;
    } case_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_sel;
    logic [31:0] cap_wdata;
    int          req_cycles;
    bit          held_ok;
    bit          stall_ok;

    // Reference byte-lane enables: lanes off .. off+size-1.
    function automatic logic [3:0] m_sel(input int size, input logic [1:0] off);
        logic [3:0] s;
        for (int b = 0; b < 4; b++) s[b] = (b >= int'(off)) && (b < int'(off) + size);
        return s;
    endfunction

    // Reference write data: the low 'size' bytes of rs2 repeated across the word.
    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] rs2);
        logic [31:0] d;
        for (int b = 0; b < 4; b++) d[8*b +: 8] = rs2[8*(b % size) +: 8];
        return d;
    endfunction

    // Reference load formatting.
    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*int'(off) +: 8];
        h = (off == 2'd2) ? w[31:16] : w[15:0];
        case (op)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic case_t mk(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata, input int delay,
                                 input logic [3:0] sel, input logic [31:0] wdata, input logic [31:0] res);
        case_t c;
        c.ld = ld; c.st = st; c.addr = addr; c.rs2 = rs2; c.rdata = rdata;
        c.delay = delay; c.sel = sel; c.wdata = wdata; c.res = res;
        return c;
    endfunction

    task automatic idle_inputs();
        exe_valid_i = 1'b0; mem_ld_ops_i = LD_NONE; mem_st_ops_i = ST_NONE;
        flush_i = 1'b0; alu_result_i = 32'h0; rs2_data_i = 32'h0;
    endtask

    task automatic drive_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr, input logic [31:0] rs2);
        exe_valid_i = 1'b1; mem_ld_ops_i = ld; mem_st_ops_i = st;
        alu_result_i = addr; rs2_data_i = rs2;
    endtask

    task automatic push_exp(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Bus responder/monitor: plays 'delay' wait cycles then ack, optional flush in one BUS cycle.
    task automatic run_bus(input int delay, input logic [31:0] rdata, input int flush_at);
        req_cycles = 0; held_ok = 1'b1; stall_ok = 1'b1;
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            exe_valid_i = 1'b0; mem_ld_ops_i = LD_NONE; mem_st_ops_i = ST_NONE;
            #1;
            if (i == 0) begin
                cap_we = dbus_we_o; cap_addr = dbus_addr_o; cap_sel = dbus_sel_o; cap_wdata = dbus_wdata_o;
            end else if ({dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o} !== {cap_we, cap_addr, cap_sel, cap_wdata}) begin
                held_ok = 1'b0;
            end
            if (dbus_req_o === 1'b1) req_cycles++;
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            flush_i      = (i == flush_at);
            dbus_ack_i   = (i == delay);
            dbus_rdata_i = (i == delay) ? rdata : 32'hDEAD_BEEF;
        end
        @(negedge clk);
        dbus_ack_i = 1'b0; flush_i = 1'b0; dbus_rdata_i = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; idle_inputs(); dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({dbus_req_o, dbus_we_o, lsu_done_o} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_ctrl: got req/we/done=%b want 000", {dbus_req_o, dbus_we_o, lsu_done_o});
        end
        checks++;
        if (dbus_addr_o !== 32'h0 || dbus_wdata_o !== 32'h0 || dbus_sel_o !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_bus: got addr=%h wdata=%h sel=%b want zeros", dbus_addr_o, dbus_wdata_o, dbus_sel_o);
        end
        checks++;
        if (lsu_rdata_o !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h want 00000000", lsu_rdata_o);
        end
        checks++;
        if ({stall_o, ld_misalign_o, st_misalign_o} !== 3'b000 || exc_addr_o !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_comb: got stall/ldm/stm=%b exc=%h want 000/0", {stall_o, ld_misalign_o, st_misalign_o}, exc_addr_o);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_directed();
        case_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(LB,      ST_NONE, 32'h0000_1003, 32'h0,         32'h80FF_FF12, 0, 4'b1000, 32'h0,         32'hFFFF_FF80));
        tbl.push_back(mk(LD_NONE, SH,      32'h0000_2002, 32'h1234_ABCD, 32'h0,         3, 4'b1100, 32'hABCD_ABCD, 32'h0));
        tbl.push_back(mk(LHU,     ST_NONE, 32'h0000_0002, 32'h0,         32'hBEEF_0000, 0, 4'b1100, 32'h0,         32'h0000_BEEF));
        tbl.push_back(mk(LH,      ST_NONE, 32'h0000_0000, 32'h0,         32'h1234_8001, 1, 4'b0011, 32'h0,         32'hFFFF_8001));
        tbl.push_back(mk(LW,      ST_NONE, 32'h0000_0004, 32'h0,         32'hCAFE_BABE, 2, 4'b1111, 32'h0,         32'hCAFE_BABE));
        tbl.push_back(mk(LD_NONE, SB,      32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 4'b0010, 32'hA5A5_A5A5, 32'h0));
        tbl.push_back(mk(LD_NONE, SW,      32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1, 4'b1111, 32'hDEAD_BEEF, 32'h0));
        tbl.push_back(mk(LBU,     ST_NONE, 32'h0000_0002, 32'h0,         32'h0080_0000, 0, 4'b0100, 32'h0,         32'h0000_0080));
        tbl.push_back(mk(LW,      SB,      32'h0000_0010, 32'h0000_00FF, 32'h1122_3344, 0, 4'b1111, 32'h0,         32'h1122_3344));
        foreach (tbl[k]) begin
            @(negedge clk);
            drive_op(tbl[k].ld, tbl[k].st, tbl[k].addr, tbl[k].rs2);
            push_exp(tbl[k].ld == LD_NONE, tbl[k].addr, tbl[k].sel, tbl[k].wdata, tbl[k].res);
            #1;
            checks++;
            if ({stall_o, dbus_req_o} !== 2'b10) begin
                errors++; $display("[TB] FAIL dir%0d_accept: got stall/req=%b want 10", k, {stall_o, dbus_req_o});
            end
            run_bus(tbl[k].delay, tbl[k].rdata, -1);
            checks++;
            if (req_cycles != tbl[k].delay + 1 || !held_ok || !stall_ok) begin
                errors++; $display("[TB] FAIL dir%0d_hold: got req_cycles=%0d held=%0d stall=%0d want %0d/1/1", k, req_cycles, held_ok, stall_ok, tbl[k].delay + 1);
            end
            e = sb.pop_front();
            checks++;
            if ({cap_we, cap_addr, cap_sel, cap_wdata} !== {e.we, e.addr, e.sel, e.wdata}) begin
                errors++; $display("[TB] FAIL dir%0d_req: got we=%b addr=%h sel=%b wdata=%h want we=%b addr=%h sel=%b wdata=%h",
                                   k, cap_we, cap_addr, cap_sel, cap_wdata, e.we, e.addr, e.sel, e.wdata);
            end
            checks++;
            if (lsu_done_o !== 1'b1 || lsu_rdata_o !== e.rdata || stall_o !== 1'b0) begin
                errors++; $display("[TB] FAIL dir%0d_done: got done=%b rdata=%h stall=%b want 1/%h/0", k, lsu_done_o, lsu_rdata_o, stall_o, e.rdata);
            end
            @(negedge clk);
            #1;
            checks++;
            if (lsu_done_o !== 1'b0) begin
                errors++; $display("[TB] FAIL dir%0d_pulse: got done=%b want 0", k, lsu_done_o);
            end
        end
    endtask

    task automatic test_misalign();
        case_t tbl[$];
        tbl.push_back(mk(LW,      ST_NONE, 32'h0000_1001, 32'h0, 32'h0, 0, 4'b0010, 32'h0, 32'h0));
        tbl.push_back(mk(LHU,     ST_NONE, 32'h0000_0003, 32'h0, 32'h0, 0, 4'b0010, 32'h0, 32'h0));
        tbl.push_back(mk(LD_NONE, SH,      32'h0000_0005, 32'h0, 32'h0, 0, 4'b0001, 32'h0, 32'h0));
        tbl.push_back(mk(LD_NONE, SW,      32'h0000_0402, 32'h0, 32'h0, 0, 4'b0001, 32'h0, 32'h0));
        foreach (tbl[k]) begin
            @(negedge clk);
            drive_op(tbl[k].ld, tbl[k].st, tbl[k].addr, 32'h5555_5555);
            #1;
            checks++;
            if ({ld_misalign_o, st_misalign_o} !== tbl[k].sel[1:0] || exc_addr_o !== tbl[k].addr || stall_o !== 1'b0) begin
                errors++; $display("[TB] FAIL mis%0d_exc: got ldm/stm=%b exc=%h stall=%b want %b/%h/0",
                                   k, {ld_misalign_o, st_misalign_o}, exc_addr_o, stall_o, tbl[k].sel[1:0], tbl[k].addr);
            end
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if (dbus_req_o !== 1'b0) begin
                errors++; $display("[TB] FAIL mis%0d_noreq: got req=%b want 0", k, dbus_req_o);
            end
        end
    endtask

    task automatic test_non_mem();
        @(negedge clk);
        drive_op(LD_NONE, ST_NONE, 32'h0000_1000, 32'h0);
        #1;
        checks++;
        if ({stall_o, ld_misalign_o, st_misalign_o} !== 3'b000) begin
            errors++; $display("[TB] FAIL nonmem_pass: got stall/ldm/stm=%b want 000", {stall_o, ld_misalign_o, st_misalign_o});
        end
        @(negedge clk);
        drive_op(LW, ST_NONE, 32'h0000_1001, 32'h0);
        flush_i = 1'b1;
        #1;
        checks++;
        if ({stall_o, ld_misalign_o, st_misalign_o} !== 3'b000 || dbus_req_o !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_idle: got stall/ldm/stm=%b req=%b want 000/0", {stall_o, ld_misalign_o, st_misalign_o}, dbus_req_o);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dbus_req_o !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_idle_noreq: got req=%b want 0", dbus_req_o);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        @(negedge clk);
        drive_op(LW, ST_NONE, 32'h0000_0040, 32'h0);
        push_exp(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 32'h0);
        run_bus(3, 32'h1234_5678, 1);
        e = sb.pop_front();
        checks++;
        if (req_cycles != 4 || !held_ok || cap_addr !== e.addr || cap_sel !== e.sel) begin
            errors++; $display("[TB] FAIL flush_bus_hold: got req_cycles=%0d held=%0d addr=%h sel=%b want 4/1/%h/%b", req_cycles, held_ok, cap_addr, cap_sel, e.addr, e.sel);
        end
        drive_op(LB, ST_NONE, 32'h0000_0041, 32'h0);
        push_exp(1'b0, 32'h0000_0041, 4'b0010, 32'h0, 32'h0000_0056);
        #1;
        checks++;
        if (lsu_done_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_no_done: got done=%b stall=%b want 0/1", lsu_done_o, stall_o);
        end
        run_bus(0, 32'h0000_5600, -1);
        e = sb.pop_front();
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== e.rdata || cap_addr !== e.addr) begin
            errors++; $display("[TB] FAIL flush_recover: got done=%b rdata=%h addr=%h want 1/%h/%h", lsu_done_o, lsu_rdata_o, cap_addr, e.rdata, e.addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        drive_op(LW, ST_NONE, 32'h0000_0100, 32'h0);
        push_exp(1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hA5A5_0001);
        run_bus(0, 32'hA5A5_0001, -1);
        e = sb.pop_front();
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== e.rdata) begin
            errors++; $display("[TB] FAIL b2b_first: got done=%b rdata=%h want 1/%h", lsu_done_o, lsu_rdata_o, e.rdata);
        end
        drive_op(LB, ST_NONE, 32'h0000_0101, 32'h0);
        push_exp(1'b0, 32'h0000_0101, 4'b0010, 32'h0, 32'hFFFF_FF99);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_resp_ignore: got stall=%b want 0", stall_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_accept: got stall=%b want 1", stall_o);
        end
        run_bus(0, 32'h0000_9900, -1);
        e = sb.pop_front();
        checks++;
        if (lsu_done_o !== 1'b1 || lsu_rdata_o !== e.rdata || cap_sel !== e.sel) begin
            errors++; $display("[TB] FAIL b2b_second: got done=%b rdata=%h sel=%b want 1/%h/%b", lsu_done_o, lsu_rdata_o, cap_sel, e.rdata, e.sel);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbus_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_quiet: got req=%b done=%b want 0/0", dbus_req_o, lsu_done_o);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        @(negedge clk);
        drive_op(LD_NONE, SW, 32'h0000_0080, 32'h0BAD_F00D);
        push_exp(1'b1, 32'h0000_0080, 4'b1111, 32'h0BAD_F00D, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        e = sb.pop_front();
        checks++;
        if (dbus_req_o !== 1'b1 || {dbus_we_o, dbus_addr_o, dbus_wdata_o} !== {e.we, e.addr, e.wdata}) begin
            errors++; $display("[TB] FAIL rstab_req: got req=%b we=%b addr=%h wdata=%h want 1/%b/%h/%h", dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, e.we, e.addr, e.wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dbus_req_o !== 1'b0 || stall_o !== 1'b0 || dbus_we_o !== 1'b0) begin
            errors++; $display("[TB] FAIL rstab_drop: got req=%b stall=%b we=%b want 0/0/0", dbus_req_o, stall_o, dbus_we_o);
        end
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'h7777_7777;
        @(negedge clk);
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        #1;
        checks++;
        if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin
            errors++; $display("[TB] FAIL rstab_stray_ack: got done=%b rdata=%h want 0/00000000", lsu_done_o, lsu_rdata_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (lsu_done_o !== 1'b0) begin
            errors++; $display("[TB] FAIL rstab_quiet: got done=%b want 0", lsu_done_o);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [31:0] addr, rs2, rdata;
        logic [2:0]  ld;
        logic [1:0]  st, off;
        int          size, delay;
        bit          is_ld;
        for (int n = 0; n < 24; n++) begin
            is_ld = 1'($urandom_range(0, 1));
            if (is_ld) begin
                ld = 3'($urandom_range(1, 5)); st = ST_NONE;
                size = (ld == LB || ld == LBU) ? 1 : (ld == LW) ? 4 : 2;
            end else begin
                st = 2'($urandom_range(1, 3)); ld = LD_NONE;
                size = (st == SB) ? 1 : (st == SH) ? 2 : 4;
            end
            off = 2'($urandom_range(0, 3));
            if (size == 2) off[0] = 1'b0;
            if (size == 4) off = 2'b00;
            addr = $urandom; addr[1:0] = off;
            rs2 = $urandom; rdata = $urandom; delay = $urandom_range(0, 2);
            @(negedge clk);
            drive_op(ld, st, addr, rs2);
            push_exp(!is_ld, addr, m_sel(size, off), is_ld ? 32'h0 : m_wdata(size, rs2), is_ld ? m_load(ld, off, rdata) : 32'h0);
            run_bus(delay, rdata, -1);
            e = sb.pop_front();
            checks++;
            if ({cap_we, cap_addr, cap_sel, cap_wdata} !== {e.we, e.addr, e.sel, e.wdata} || req_cycles != delay + 1) begin
                errors++; $display("[TB] FAIL rnd%0d_req: got we=%b addr=%h sel=%b wdata=%h cyc=%0d want %b/%h/%b/%h/%0d",
                                   n, cap_we, cap_addr, cap_sel, cap_wdata, req_cycles, e.we, e.addr, e.sel, e.wdata, delay + 1);
            end
            checks++;
            if (lsu_done_o !== 1'b1 || lsu_rdata_o !== e.rdata) begin
                errors++; $display("[TB] FAIL rnd%0d_done: got done=%b rdata=%h want 1/%h", n, lsu_done_o, lsu_rdata_o, e.rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_non_mem();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
